amstrad_mem_ctrl: RTL and testbench
===================================

AMSTRAD_MEM_CTRL -- requirements
Module: amstrad_mem_ctrl

Interface
REQ-001 SHALL provide parameter READ_LAT, default 2, cycles from read issue to mem_rdata capture (legal 1..7).
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports cpu_addr  in  23  CPU byte address; cpu_rd  in  1  read level; cpu_wr  in  1  write level; cpu_wdata  in  8  write byte.
REQ-005 SHALL have ports cpu_rdata  out  8  read byte; cpu_ready  out  1  high when no CPU access is outstanding.
REQ-006 SHALL have ports vram_addr  in  15  video word address; vram_req  in  1  one-cycle fetch strobe; vram_dout  out  16  fetched word; vram_valid  out  1  one-cycle data strobe.
REQ-007 SHALL have ports mem_a  out  22  word address; mem_oe  out  1  read strobe; mem_we  out  1  write strobe; mem_be  out  2  byte enables; mem_wdata  out  16  write word; mem_rdata  in  16  read word.

Function
REQ-008 SHALL detect CPU requests on the rising edge of cpu_rd or cpu_wr (registered previous level), one access per edge.
REQ-009 SHALL ignore a CPU edge when cpu_rd and cpu_wr are both high in that cycle.
REQ-010 SHALL use states IDLE, VRD, CRD, CWR; IDLE->VRD on VRAM request, IDLE->CRD on CPU read, IDLE->CWR on CPU write.
REQ-011 SHALL give VRAM priority when VRAM and CPU requests are both pending in IDLE.
REQ-012 SHALL hold one pending VRAM request and one pending CPU request while busy; a newer VRAM strobe overwrites the pending VRAM address.
REQ-013 SHALL drive mem_oe or mem_we high for exactly the first cycle of a state, with mem_a valid in that cycle.
REQ-014 SHALL form CPU word address as cpu_addr[22:1]; mem_be = 2'b01 when cpu_addr[0]=0, 2'b10 when 1; mem_wdata = {cpu_wdata, cpu_wdata}.
REQ-015 SHALL form VRAM word address as {7'b0, vram_addr}, mem_be = 2'b11.
REQ-016 SHALL in VRD/CRD count READ_LAT cycles after issue, capture mem_rdata, then return to IDLE next cycle.
REQ-017 SHALL on VRD capture load vram_dout and pulse vram_valid one cycle.
REQ-018 SHALL on CRD capture load cpu_rdata with the byte selected by cpu_addr[0] (0 -> [7:0], 1 -> [15:8]) and raise cpu_ready in the same cycle.
REQ-019 SHALL complete CWR in one cycle and return to IDLE.
REQ-020 SHALL drop cpu_ready the cycle after a CPU edge is detected.
REQ-021 SHALL keep mem_oe, mem_we low in IDLE and during wait cycles.

Reset
REQ-022 SHALL on reset_n low set state IDLE, clear both pending requests and edge registers, mid-operation included.
REQ-023 SHALL reset cpu_rdata=8'hFF, cpu_ready=1, vram_dout=16'h0000, vram_valid=0, mem_oe=0, mem_we=0, mem_be=0, mem_a=0, mem_wdata=0.

Configuration
REQ-024 SHALL, with AMSTRAD_MEM_POSTED_WR_EN defined, accept a CPU write into a one-entry buffer keeping cpu_ready high, performing CWR when granted; a second write while buffer full drops cpu_ready until drained.
REQ-025 SHALL, without AMSTRAD_MEM_POSTED_WR_EN, hold cpu_ready low from write detection until CWR completes.

Verification
REQ-026 Read: mem preloaded word 0x000010=16'hA55A, cpu_rd rise at addr 23'h000021 -> mem_oe one cycle with mem_a=22'h000010, cpu_rdata=8'hA5 and cpu_ready=1 after READ_LAT.
REQ-027 Write: cpu_wr rise, addr 23'h000040, data 8'h3C -> mem_we one cycle, mem_a=22'h000020, mem_be=2'b01, mem_wdata=16'h3C3C.
REQ-028 Collision: vram_req (addr 15'h1234) and CPU read edge same cycle -> VRAM access first (mem_a=22'h001234), CPU read issued after vram_valid.
REQ-029 Overwrite: two vram_req (15'h0001 then 15'h0002) during a CPU read -> only 15'h0002 fetched, one vram_valid.
REQ-030 Reset mid-CRD: reset_n low during wait -> state IDLE, cpu_ready=1, cpu_rdata=8'hFF, no mem strobe after release.
REQ-031 Posted write (macro on): two back-to-back writes -> cpu_ready stays 1 on first, drops on second until first CWR drains.

Source files
------------

// File: rtl/amstrad_mem_ctrl.sv
// Amstrad memory controller: arbitrates CPU byte accesses and video word fetches onto a
// 16-bit memory. Video fetches win ties. One pending request per requester is held
// while the memory is busy.
// Define AMSTRAD_MEM_POSTED_WR_EN to post CPU writes into a one-entry buffer.
module amstrad_mem_ctrl #(
    parameter int unsigned READ_LAT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [22:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    input  logic [14:0] vram_addr,
    input  logic        vram_req,
    output logic [15:0] vram_dout,
    output logic        vram_valid,
    output logic [21:0] mem_a,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

`ifdef AMSTRAD_MEM_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    localparam logic [2:0] LAT_LAST = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {StIdle, StVrd, StCrd, StCwr} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q;
    logic        rd_q, wr_q, lsb_q;
    logic        vpend_q, vpend_d;
    logic [14:0] vaddr_q, vaddr_d;
    // Pending CPU slot; the held slot only fills in posted mode when the pending slot is full.
    logic        cpend_q, cpend_d, cwr_q, cwr_d;
    logic [22:0] caddr_q, caddr_d;
    logic [7:0]  cdata_q, cdata_d;
    logic        hpend_q, hpend_d, hwr_q, hwr_d;
    logic [22:0] haddr_q, haddr_d;
    logic [7:0]  hdata_q, hdata_d;

    logic        rd_edge, wr_edge, new_cpu, vreq_eff;
    logic        ceff_valid, ceff_wr, grant_v, grant_c, cap, ready_d, rd_out;
    logic [22:0] ceff_addr;
    logic [7:0]  ceff_data;
    logic [21:0] iss_a;
    logic [1:0]  iss_be;

    // Edge detection, arbitration, pending-slot bookkeeping and next cpu_ready.
    always_comb begin
        rd_edge    = cpu_rd & ~rd_q & ~(cpu_rd & cpu_wr);
        wr_edge    = cpu_wr & ~wr_q & ~(cpu_rd & cpu_wr);
        new_cpu    = rd_edge | wr_edge;
        vreq_eff   = vram_req | vpend_q;
        vaddr_d    = vram_req ? vram_addr : vaddr_q;
        ceff_valid = cpend_q | new_cpu;
        ceff_wr    = cpend_q ? cwr_q : wr_edge;
        ceff_addr  = cpend_q ? caddr_q : cpu_addr;
        ceff_data  = cpend_q ? cdata_q : cpu_wdata;

        grant_v = 1'b0;
        grant_c = 1'b0;
        cap     = 1'b0;
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (vreq_eff) begin
                    grant_v = 1'b1;
                    state_d = StVrd;
                end else if (ceff_valid) begin
                    grant_c = 1'b1;
                    state_d = ceff_wr ? StCwr : StCrd;
                end
            end
            StVrd, StCrd: begin
                if (cnt_q == LAT_LAST) begin
                    cap     = 1'b1;
                    state_d = StIdle;
                end
            end
            StCwr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (grant_v) begin
            iss_a  = {7'b0, vaddr_d};
            iss_be = 2'b11;
        end else begin
            iss_a  = ceff_addr[22:1];
            iss_be = ceff_addr[0] ? 2'b10 : 2'b01;
        end

        vpend_d = vreq_eff & ~grant_v;

        cpend_d = cpend_q;
        cwr_d   = cwr_q;
        caddr_d = caddr_q;
        cdata_d = cdata_q;
        hpend_d = hpend_q;
        hwr_d   = hwr_q;
        haddr_d = haddr_q;
        hdata_d = hdata_q;
        // A grant consumes the pending slot; the held entry moves up behind it.
        if (grant_c) begin
            cpend_d = hpend_q;
            cwr_d   = hwr_q;
            caddr_d = haddr_q;
            cdata_d = hdata_q;
            hpend_d = 1'b0;
        end
        // A new edge not issued straight from idle is queued; it is dropped if no slot is free.
        if (new_cpu && !(grant_c && !cpend_q)) begin
            if (!cpend_d) begin
                cpend_d = 1'b1;
                cwr_d   = wr_edge;
                caddr_d = cpu_addr;
                cdata_d = cpu_wdata;
            end else if (POSTED && !hpend_d) begin
                hpend_d = 1'b1;
                hwr_d   = wr_edge;
                haddr_d = cpu_addr;
                hdata_d = cpu_wdata;
            end
        end

        rd_out = (cpend_d & ~cwr_d) | (hpend_d & ~hwr_d) | (state_d == StCrd);
        if (POSTED) begin
            // A buffered write blocks the CPU only while another write sits behind it.
            ready_d = ~(rd_out | hpend_d | ((state_d == StCwr) & cpend_d));
        end else begin
            ready_d = ~(cpend_d | (state_d == StCrd) | (state_d == StCwr));
        end
    end

    // State, request slots and registered memory/CPU/video outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            lsb_q      <= 1'b0;
            vpend_q    <= 1'b0;
            vaddr_q    <= 15'd0;
            cpend_q    <= 1'b0;
            cwr_q      <= 1'b0;
            caddr_q    <= 23'd0;
            cdata_q    <= 8'd0;
            hpend_q    <= 1'b0;
            hwr_q      <= 1'b0;
            haddr_q    <= 23'd0;
            hdata_q    <= 8'd0;
            cpu_rdata  <= 8'hFF;
            cpu_ready  <= 1'b1;
            vram_dout  <= 16'h0000;
            vram_valid <= 1'b0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 2'b00;
            mem_a      <= 22'd0;
            mem_wdata  <= 16'd0;
        end else begin
            state_q    <= state_d;
            rd_q       <= cpu_rd;
            wr_q       <= cpu_wr;
            vpend_q    <= vpend_d;
            vaddr_q    <= vaddr_d;
            cpend_q    <= cpend_d;
            cwr_q      <= cwr_d;
            caddr_q    <= caddr_d;
            cdata_q    <= cdata_d;
            hpend_q    <= hpend_d;
            hwr_q      <= hwr_d;
            haddr_q    <= haddr_d;
            hdata_q    <= hdata_d;
            cpu_ready  <= ready_d;
            mem_oe     <= grant_v | (grant_c & ~ceff_wr);
            mem_we     <= grant_c & ceff_wr;
            vram_valid <= cap && (state_q == StVrd);
            if (grant_v || grant_c) begin
                mem_a  <= iss_a;
                mem_be <= iss_be;
                cnt_q  <= 3'd0;
                lsb_q  <= ceff_addr[0];
            end else begin
                cnt_q  <= cnt_q + 3'd1;
            end
            if (grant_c && ceff_wr) begin
                mem_wdata <= {ceff_data, ceff_data};
            end
            if (cap && (state_q == StVrd)) begin
                vram_dout <= mem_rdata;
            end
            if (cap && (state_q == StCrd)) begin
                cpu_rdata <= lsb_q ? mem_rdata[15:8] : mem_rdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_amstrad_mem_ctrl.sv
// Scoreboard bench for amstrad_mem_ctrl: stimulus pushes expected events, a monitor on the
// falling edge pops and compares memory strobes, video data strobes and cpu_ready rises.
module tb_amstrad_mem_ctrl;

    localparam int unsigned READ_LAT = 2;
    localparam int KMemRd = 0, KMemWr = 1, KVram = 2, KCpu = 3;

    typedef struct {
        int          kind;
        logic [21:0] a;
        logic [1:0]  be;
        logic [15:0] d;
        bit          cd;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [22:0] cpu_addr = '0;
    logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [14:0] vram_addr = '0;
    logic        vram_req = 1'b0;
    logic [15:0] vram_dout;
    logic        vram_valid;
    logic [21:0] mem_a;
    logic        mem_oe, mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata, mem_rdata;

    logic [15:0] mem [0:8191];
    logic [12:0] rd_idx = '0;
    ev_t         sbq[$];
    int          errors = 0, checks = 0, cyc = 0, last_rd = 0;
    bit          prev_rdy = 1'b1;

    amstrad_mem_ctrl #(.READ_LAT(READ_LAT)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .vram_addr(vram_addr), .vram_req(vram_req), .vram_dout(vram_dout),
        .vram_valid(vram_valid), .mem_a(mem_a), .mem_oe(mem_oe), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: address latched on the read strobe, data returned from that word.
    always @(posedge clk) begin
        if (mem_oe) rd_idx <= mem_a[12:0];
        if (mem_we) begin
            if (mem_be[0]) mem[mem_a[12:0]][7:0]  <= mem_wdata[7:0];
            if (mem_be[1]) mem[mem_a[12:0]][15:8] <= mem_wdata[15:8];
        end
    end
    assign mem_rdata = mem[rd_idx];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(input int k, input logic [21:0] a, input logic [1:0] be,
                        input logic [15:0] d, input bit cd);
        ev_t e;
        e.kind = k; e.a = a; e.be = be; e.d = d; e.cd = cd;
        sbq.push_back(e);
    endtask

    task automatic got_ev(input int k, input logic [21:0] a, input logic [1:0] be,
                          input logic [15:0] d);
        ev_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d a=%h d=%h want none", k, a, d);
        end else begin
            e = sbq.pop_front();
            chk("event_kind", k, e.kind);
            if (e.kind == k) begin
                if (k == KMemRd || k == KMemWr) begin
                    chk("mem_a", a, e.a);
                    chk("mem_be", be, e.be);
                end
                if (k == KMemWr || k == KVram || (k == KCpu && e.cd)) chk("data", d, e.d);
                if (k == KVram || (k == KCpu && e.cd)) chk("read_latency", cyc - last_rd, READ_LAT);
            end
        end
    endtask

    // Monitor: one strobe per cycle at most; every DUT output event must match the queue head.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_rdy = 1'b1;
        end else begin
            if (mem_oe && mem_we) chk("oe_we_exclusive", 1, 0);
            if (mem_oe) begin
                got_ev(KMemRd, mem_a, mem_be, 16'h0);
                last_rd = cyc;
            end
            if (mem_we) got_ev(KMemWr, mem_a, mem_be, mem_wdata);
            if (vram_valid) got_ev(KVram, 22'h0, 2'b00, vram_dout);
            if (cpu_ready && !prev_rdy) got_ev(KCpu, 22'h0, 2'b00, {8'h00, cpu_rdata});
            prev_rdy = cpu_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
        tick(2);
    endtask

    task automatic cpu_read(input logic [22:0] addr, input logic [7:0] exp_byte);
        push(KMemRd, addr[22:1], addr[0] ? 2'b10 : 2'b01, 16'h0, 1'b0);
        push(KCpu, 22'h0, 2'b00, {8'h00, exp_byte}, 1'b1);
        cpu_addr = addr;
        cpu_rd = 1'b1;
        tick(1);
        chk("ready_drop_rd", cpu_ready, 0);
        cpu_rd = 1'b0;
        drain();
    endtask

    task automatic cpu_write(input logic [22:0] addr, input logic [7:0] data);
        push(KMemWr, addr[22:1], addr[0] ? 2'b10 : 2'b01, {data, data}, 1'b1);
`ifndef AMSTRAD_MEM_POSTED_WR_EN
        push(KCpu, 22'h0, 2'b00, 16'h0, 1'b0);
`endif
        cpu_addr = addr;
        cpu_wdata = data;
        cpu_wr = 1'b1;
        tick(1);
`ifdef AMSTRAD_MEM_POSTED_WR_EN
        chk("ready_posted_wr", cpu_ready, 1);
`else
        chk("ready_drop_wr", cpu_ready, 0);
`endif
        cpu_wr = 1'b0;
        drain();
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        mem[13'h0010] = 16'hA55A;
        mem[13'h1234] = 16'hBEEF;
        mem[13'h0001] = 16'h1111;
        mem[13'h0002] = 16'h2222;

        tick(2);
        chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
        chk("rst_cpu_ready", cpu_ready, 1);
        chk("rst_vram_dout", vram_dout, 16'h0000);
        chk("rst_vram_valid", vram_valid, 0);
        chk("rst_mem_oe", mem_oe, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 2'b00);
        chk("rst_mem_a", mem_a, 22'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        reset_n = 1'b1;
        tick(2);

        // Basic read of the high byte, writes to both byte lanes, read-backs.
        cpu_read(23'h000021, 8'hA5);
        cpu_read(23'h000020, 8'h5A);
        cpu_write(23'h000040, 8'h3C);
        cpu_write(23'h000041, 8'h77);
        cpu_read(23'h000040, 8'h3C);
        cpu_read(23'h000041, 8'h77);

        // Simultaneous read and write rising edges must be ignored.
        cpu_rd = 1'b1;
        cpu_wr = 1'b1;
        tick(1);
        chk("both_ignored_ready", cpu_ready, 1);
        tick(1);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        tick(4);

        // Collision: video fetch wins, CPU read follows after vram_valid.
        push(KMemRd, 22'h001234, 2'b11, 16'h0, 1'b0);
        push(KVram, 22'h0, 2'b00, 16'hBEEF, 1'b1);
        push(KMemRd, 22'h000010, 2'b10, 16'h0, 1'b0);
        push(KCpu, 22'h0, 2'b00, 16'h00A5, 1'b1);
        vram_addr = 15'h1234;
        vram_req = 1'b1;
        cpu_addr = 23'h000021;
        cpu_rd = 1'b1;
        tick(1);
        chk("collision_ready_drop", cpu_ready, 0);
        vram_req = 1'b0;
        cpu_rd = 1'b0;
        drain();

        // Overwrite: two video strobes during a CPU read, only the newer one is fetched.
        push(KMemRd, 22'h000010, 2'b10, 16'h0, 1'b0);
        push(KCpu, 22'h0, 2'b00, 16'h00A5, 1'b1);
        push(KMemRd, 22'h000002, 2'b11, 16'h0, 1'b0);
        push(KVram, 22'h0, 2'b00, 16'h2222, 1'b1);
        cpu_addr = 23'h000021;
        cpu_rd = 1'b1;
        tick(1);
        cpu_rd = 1'b0;
        vram_req = 1'b1;
        vram_addr = 15'h0001;
        tick(1);
        vram_addr = 15'h0002;
        tick(1);
        vram_req = 1'b0;
        drain();

        // Reset during the read wait: outputs return to reset values, nothing issued after.
        cpu_addr = 23'h000021;
        cpu_rd = 1'b1;
        tick(1);
        chk("midrd_oe_issued", mem_oe, 1);
        cpu_rd = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("midrd_rst_ready", cpu_ready, 1);
        chk("midrd_rst_rdata", cpu_rdata, 8'hFF);
        chk("midrd_rst_oe", mem_oe, 0);
        tick(2);
        reset_n = 1'b1;
        tick(8);

`ifdef AMSTRAD_MEM_POSTED_WR_EN
        // Posted writes: first write buffered behind a video fetch, second stalls the CPU.
        push(KMemRd, 22'h001234, 2'b11, 16'h0, 1'b0);
        push(KVram, 22'h0, 2'b00, 16'hBEEF, 1'b1);
        push(KMemWr, 22'h000020, 2'b01, 16'h1111, 1'b1);
        push(KCpu, 22'h0, 2'b00, 16'h0, 1'b0);
        push(KMemWr, 22'h000020, 2'b10, 16'h2222, 1'b1);
        vram_addr = 15'h1234;
        vram_req = 1'b1;
        tick(1);
        vram_req = 1'b0;
        cpu_addr = 23'h000040;
        cpu_wdata = 8'h11;
        cpu_wr = 1'b1;
        tick(1);
        chk("posted_first_ready", cpu_ready, 1);
        cpu_wr = 1'b0;
        tick(1);
        cpu_addr = 23'h000041;
        cpu_wdata = 8'h22;
        cpu_wr = 1'b1;
        tick(1);
        chk("posted_second_drop", cpu_ready, 0);
        cpu_wr = 1'b0;
        tick(1);
        chk("posted_drained_ready", cpu_ready, 1);
        drain();
        cpu_read(23'h000041, 8'h22);
`endif

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
